// File: rtl/down_count_timer.sv
// Loadable down-counting timer with a one-cycle done strobe at terminal count.
// Optional periodic mode: define TIMER_AUTO_RELOAD_EN to restart from the load value after DONE.
module down_count_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  // State, count and flags advance together; priority is load > stop > start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else if (load) begin
      state <= IDLE;
      count <= load_value;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_reg <= load_value;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A zero count must never enter RUN, so start is dropped there.
          if (!stop && start && (count != '0)) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (enable) begin
            count <= count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
            count <= reload_reg;
            busy  <= 1'b1;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
